// File: rtl/leaf_token_collector_if.sv
// leaf_token_collector_if: source-side token handshakes plus the collected FIFO output stream.
interface leaf_token_collector_if #(
  parameter int NUM_SRC = 10,
  parameter int DATA_W  = 8
);
  localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [IW-1:0]             out_src_id;
  logic [15:0]               accept_cnt;
  modport master (
    output src_valid, src_data, out_ready,
    input  src_ready, out_valid, out_data, out_src_id, accept_cnt
  );
  modport slave (
    input  src_valid, src_data, out_ready,
    output src_ready, out_valid, out_data, out_src_id, accept_cnt
  );
endinterface

// File: rtl/leaf_token_collector.sv
// leaf_token_collector: round-robin merge of sibling leaf tokens into one tagged FIFO stream.
module leaf_token_collector #(
  parameter int NUM_SRC = 10,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4
) (
  input logic clk,
  input logic rst,
  leaf_token_collector_if.slave bus
);
  localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  localparam int AW = $clog2(DEPTH);
  logic [IW-1:0]          r_rr_ptr;
  logic [AW:0]            r_count;
  logic [AW-1:0]          r_wp;
  logic [AW-1:0]          r_rp;
  logic [IW+DATA_W-1:0]   r_mem [DEPTH];
  logic [15:0]            r_accept_cnt;
  logic [IW-1:0]          w_gidx;
  logic [NUM_SRC-1:0]     w_grant;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  // Scan offsets from the far end down so the nearest requester above rr_ptr wins.
  always_comb begin : arb
    int j;
    w_gidx = '0;
    j = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (bus.src_valid[j]) w_gidx = IW'(j);
    end
  end
  assign w_full  = r_count == (AW+1)'(DEPTH);
  assign w_grant = (|bus.src_valid && !w_full && !rst) ? NUM_SRC'(1) << w_gidx : '0;
  assign w_push  = |w_grant;
  assign w_pop   = bus.out_valid && bus.out_ready;
  assign bus.src_ready  = w_grant;
  assign bus.out_valid  = r_count != '0;
  assign {bus.out_src_id, bus.out_data} = r_mem[r_rp];
  assign bus.accept_cnt = r_accept_cnt;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {w_gidx, bus.src_data[w_gidx*DATA_W +: DATA_W]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_count      <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_accept_cnt <= '0;
    end else begin
      if (w_push) r_rr_ptr <= (w_gidx == IW'(NUM_SRC - 1)) ? '0 : w_gidx + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_wp    <= r_wp + AW'(w_push);
      r_rp    <= r_rp + AW'(w_pop);
      if (w_push && r_accept_cnt != 16'hFFFF) r_accept_cnt <= r_accept_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_leaf_token_collector.sv
// tb_leaf_token_collector: directed checks of grant order, FIFO fill/drain, reset and counter saturation.
module tb_leaf_token_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  leaf_token_collector_if #(.NUM_SRC(10), .DATA_W(8)) bus ();
  leaf_token_collector #(.NUM_SRC(10), .DATA_W(8), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.src_valid = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) bus.src_data[i*8 +: 8] = 8'h10 + 8'(i);
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_accept_cnt", 32'(bus.accept_cnt), 0);
    bus.src_valid = 10'h3FF;
    #1;
    chk("rst_no_grant", 32'(bus.src_ready), 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        chk("rr_out_valid", 32'(bus.out_valid), 1);
        chk("rr_out_src_id", 32'(bus.out_src_id), 32'((i - 1) % 10));
        chk("rr_out_data", 32'(bus.out_data), 32'h10 + 32'((i - 1) % 10));
      end
      chk("rr_grant", 32'(bus.src_ready), 32'(1) << (i % 10));
      step();
    end
    chk("rr_accept_cnt", 32'(bus.accept_cnt), 12);
    bus.src_valid = '0;
    #1;
    chk("idle_no_grant", 32'(bus.src_ready), 0);
    step();
    chk("drain_empty", 32'(bus.out_valid), 0);
    bus.src_data[3*8 +: 8] = 8'hA5;
    bus.out_ready = 1'b0;
    bus.src_valid = 10'h008;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_grant", 32'(bus.src_ready), 32'h008);
      step();
    end
    chk("full_no_grant", 32'(bus.src_ready), 0);
    chk("full_out_valid", 32'(bus.out_valid), 1);
    chk("full_accept_cnt", 32'(bus.accept_cnt), 16);
    bus.out_ready = 1'b1;
    #1;
    chk("full_pop_no_bypass", 32'(bus.src_ready), 0);
    step();
    chk("after_pop_grant", 32'(bus.src_ready), 32'h008);
    for (int i = 0; i < 4; i++) begin
      chk("a5_out_valid", 32'(bus.out_valid), 1);
      chk("a5_out_data", 32'(bus.out_data), 32'hA5);
      chk("a5_out_src_id", 32'(bus.out_src_id), 3);
      step();
    end
    bus.src_valid = '0;
    for (int i = 0; i < 4; i++) step();
    chk("a5_drained", 32'(bus.out_valid), 0);
    chk("a5_accept_cnt", 32'(bus.accept_cnt), 20);
    bus.src_valid = 10'h201;
    #1;
    chk("wrap_grant9", 32'(bus.src_ready), 32'h200);
    step();
    chk("wrap_head9", 32'(bus.out_src_id), 9);
    chk("wrap_data9", 32'(bus.out_data), 32'h19);
    chk("wrap_grant0", 32'(bus.src_ready), 32'h001);
    step();
    chk("wrap_head0", 32'(bus.out_src_id), 0);
    chk("wrap_data0", 32'(bus.out_data), 32'h10);
    chk("wrap_grant9b", 32'(bus.src_ready), 32'h200);
    step();
    bus.src_valid = '0;
    step();
    step();
    chk("wrap_drained", 32'(bus.out_valid), 0);
    chk("wrap_accept_cnt", 32'(bus.accept_cnt), 23);
    bus.out_ready = 1'b0;
    bus.src_valid = 10'h300;
    #1;
    chk("pre_rst_grant8", 32'(bus.src_ready), 32'h100);
    step();
    chk("pre_rst_grant9", 32'(bus.src_ready), 32'h200);
    step();
    chk("pre_rst_grant8b", 32'(bus.src_ready), 32'h100);
    step();
    chk("pre_rst_out_valid", 32'(bus.out_valid), 1);
    chk("pre_rst_accept_cnt", 32'(bus.accept_cnt), 26);
    chk("pre_rst_would_grant9", 32'(bus.src_ready), 32'h200);
    rst = 1'b1;
    #1;
    chk("mid_rst_no_grant", 32'(bus.src_ready), 0);
    step();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_accept_cnt", 32'(bus.accept_cnt), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_grant8", 32'(bus.src_ready), 32'h100);
    step();
    chk("post_rst_out_valid", 32'(bus.out_valid), 1);
    chk("post_rst_src_id", 32'(bus.out_src_id), 8);
    chk("post_rst_data", 32'(bus.out_data), 32'h18);
    chk("post_rst_accept_cnt", 32'(bus.accept_cnt), 1);
    bus.src_valid = '0;
    #1;
    force dut.r_accept_cnt = 16'hFFFE;
    #1;
    release dut.r_accept_cnt;
    #1;
    chk("sat_preload", 32'(bus.accept_cnt), 32'hFFFE);
    bus.out_ready = 1'b1;
    bus.src_valid = 10'h001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_accept_cnt", 32'(bus.accept_cnt), 32'hFFFF);
    end
    bus.src_valid = '0;
    step();
    chk("sat_hold", 32'(bus.accept_cnt), 32'hFFFF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
